csr_trap_ctrl: RTL and testbench
================================

Name: csr_trap_ctrl

Overview:
Sequencer that drives the single write port of the machine-mode CSR file. On a qualified interrupt it saves mepc, mcause and mstatus in three consecutive cycles, one register per cycle, then redirects the PC to the mtvec handler. On mret it restores mstatus and redirects the PC to mepc. It sits between the decode/PC stage and the CSR file, and stalls the core while a sequence runs.

Parameters:
XLEN, 32, datapath and CSR width
TIMER_CAUSE, 7, mcause code for the machine timer interrupt
EXT_CAUSE, 11, mcause code for the machine external interrupt

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock, reset is asynchronous and active-high
instr_valid  in  1  an instruction is at the commit point this cycle
pc_i  in  XLEN  PC of that instruction
is_mret  in  1  decoded mret at the commit point
timer_irq  in  1  level-sensitive timer interrupt
ext_irq  in  1  level-sensitive external interrupt
mstatus_i  in  XLEN  current mstatus, read from the CSR file
mie_i  in  XLEN  current mie
mtvec_i  in  XLEN  current mtvec
mepc_i  in  XLEN  current mepc
csr_we  out  1  CSR write enable
csr_waddr  out  12  CSR write address
csr_wdata  out  XLEN  CSR write data
stall  out  1  hold fetch and decode
redirect  out  1  load the PC from redirect_pc
redirect_pc  out  XLEN  PC redirect target

Behaviour:
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_STATUS, TRAP_JMP, MRET_STATUS, MRET_JMP.
- Pending interrupt: irq_pend = mstatus_i[3] & ((ext_irq & mie_i[11]) | (timer_irq & mie_i[7])).
- Priority: external wins over timer.
- take_trap = IDLE & instr_valid & irq_pend.
- take_mret = IDLE & instr_valid & is_mret & ~irq_pend. Interrupt wins a tie; mepc then holds the mret PC, so mret re-executes after the handler.
- On take_trap, latch pc_i, cause, mstatus_i and mtvec_i, then go to SAVE_EPC.
- On take_mret, latch mstatus_i and mepc_i, then go to MRET_STATUS.
- SAVE_EPC: we=1, addr=0x341, data=latched pc.
- SAVE_CAUSE: we=1, addr=0x342, data={1'b1, cause zero-extended to XLEN-1 bits}.
- SAVE_STATUS: we=1, addr=0x300, data=latched mstatus with bit7 (MPIE)=old bit3, bit3 (MIE)=0, bits[12:11] (MPP)=2'b11.
- TRAP_JMP: redirect=1, redirect_pc={mtvec[XLEN-1:2], 2'b00}; next state IDLE.
- MRET_STATUS: we=1, addr=0x300, data=latched mstatus with bit3=old bit7, bit7=1, bits[12:11]=2'b11.
- MRET_JMP: redirect=1, redirect_pc=latched mepc; next state IDLE.
- Outputs are a combinational decode of state and latched registers. They are 0 in IDLE. csr_we, redirect, csr_waddr and csr_wdata are 0 in any state that does not drive them.
- stall = (state != IDLE) | take_trap | take_mret.
- Latency: trap accepted at cycle N; writes at N+1..N+3; redirect at N+4; IDLE at N+5. mret accepted at N: write at N+1, redirect at N+2.
- Interrupt edges arriving outside IDLE are not queued; a level still asserted on return to IDLE is taken.
- instr_valid=0 in IDLE: nothing is taken.
- Reset at any time forces IDLE and zeroes all latches and outputs. The sequence is abandoned; CSR writes already performed remain.

Optional Feature:
CSR_TRAP_VECTORED_EN
- Defined: when latched mtvec[1:0]==2'b01, TRAP_JMP target = {mtvec[XLEN-1:2],2'b00} + 4*cause. Other mode values use the base.
- Undefined: mode bits are ignored and the target is always the base.

Decomposition:
- Package csr_trap_pkg holds:
  - CSR address localparams: MSTATUS 0x300, MIE 0x304, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MIP 0x344.
  - Bit indices: MIE=3, MPIE=7, MPP=12:11, MTIE=7, MEIE=11.
  - The state enum typedef and the cause codes.
- One sub-module, csr_irq_select: combinational qualification, priority and cause encoding, outputting irq_pend and cause.

Test Plan:
- mstatus=0x8, mie=0x80, timer_irq=1, instr_valid=1, pc=0x100, mtvec=0x200 -> writes 0x341←0x100, 0x342←0x80000007, 0x300←0x1880 on cycles N+1..N+3; redirect to 0x200 at N+4.
- ext_irq and timer_irq both high, mie=0x880 -> mcause written 0x8000000B.
- mstatus=0x1880, mepc=0x104, is_mret=1 -> 0x300←0x1888 at N+1; redirect to 0x104 at N+2; stall high N..N+2.
- mstatus MIE=0 with irqs high -> no writes, stall stays 0. Same with instr_valid=0.
- rst asserted during SAVE_CAUSE -> outputs 0 immediately and state IDLE. With CSR_TRAP_VECTORED_EN, mtvec=0x201 and ext_irq -> redirect_pc=0x22C.

Source files
------------

// File: rtl/csr_trap_pkg.sv
// csr_trap_pkg
//   Shared definitions for the machine-mode trap/mret sequencer:
//   CSR addresses, mstatus/mie bit positions, interrupt cause codes
//   and the sequencer state type.
package csr_trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  // mstatus fields
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // mie fields
  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  // mcause interrupt codes
  localparam int CAUSE_M_TIMER = 7;
  localparam int CAUSE_M_EXT   = 11;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SAVE_EPC    = 3'd1,
    SAVE_CAUSE  = 3'd2,
    SAVE_STATUS = 3'd3,
    TRAP_JMP    = 3'd4,
    MRET_STATUS = 3'd5,
    MRET_JMP    = 3'd6
  } trap_state_t;

endpackage

// File: rtl/csr_irq_select.sv
// csr_irq_select
//   Combinational interrupt qualification and priority. An interrupt is
//   pending when global MIE is set and at least one source is both
//   asserted and enabled. External outranks timer.
// Ports:
//   mstatus_mie  in   mstatus.MIE
//   mie_mtie     in   mie.MTIE
//   mie_meie     in   mie.MEIE
//   timer_irq    in   level timer interrupt
//   ext_irq      in   level external interrupt
//   irq_pend     out  qualified interrupt pending
//   cause        out  cause code of the winning source (XLEN-1 bits)
module csr_irq_select #(
  parameter int XLEN        = 32,
  parameter int TIMER_CAUSE = 7,
  parameter int EXT_CAUSE   = 11
) (
  input  logic            mstatus_mie,
  input  logic            mie_mtie,
  input  logic            mie_meie,
  input  logic            timer_irq,
  input  logic            ext_irq,
  output logic            irq_pend,
  output logic [XLEN-2:0] cause
);

  localparam int CAUSE_W = XLEN - 1;

  logic ext_hit;
  logic tmr_hit;

  always_comb begin
    ext_hit  = ext_irq & mie_meie;
    tmr_hit  = timer_irq & mie_mtie;
    irq_pend = mstatus_mie & (ext_hit | tmr_hit);
    // cause is only meaningful while irq_pend is high
    cause    = ext_hit ? CAUSE_W'(EXT_CAUSE) : CAUSE_W'(TIMER_CAUSE);
  end

endmodule

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl
//   Drives the single write port of the machine-mode CSR file. A qualified
//   interrupt at the commit point saves mepc, mcause and mstatus on three
//   consecutive cycles and then redirects to the mtvec handler; mret
//   restores mstatus and redirects to mepc. The core is stalled while a
//   sequence runs.
//   Build option: CSR_TRAP_VECTORED_EN enables vectored mtvec mode
//   (mode 2'b01 -> base + 4*cause); otherwise the mode bits are ignored.
// Ports:
//   clk, rst          clock, async active-high reset
//   instr_valid       instruction at commit point
//   pc_i              its PC
//   is_mret           it is an mret
//   timer_irq/ext_irq level interrupt requests
//   mstatus_i, mie_i, mtvec_i, mepc_i   current CSR values
//   csr_we/csr_waddr/csr_wdata          CSR write port
//   stall             hold fetch/decode
//   redirect/redirect_pc                PC redirect
//
// state       | meaning
// ------------+----------------------------------------------
// IDLE        | waiting for an interrupt or mret at commit
// SAVE_EPC    | writing the interrupted PC to mepc
// SAVE_CAUSE  | writing the interrupt code to mcause
// SAVE_STATUS | writing trap-entry mstatus (MPIE<-MIE, MIE<-0)
// TRAP_JMP    | redirecting to the mtvec handler
// MRET_STATUS | writing return mstatus (MIE<-MPIE, MPIE<-1)
// MRET_JMP    | redirecting to mepc
module csr_trap_ctrl
  import csr_trap_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int TIMER_CAUSE = CAUSE_M_TIMER,
  parameter int EXT_CAUSE   = CAUSE_M_EXT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [XLEN-1:0] pc_i,
  input  logic            is_mret,
  input  logic            timer_irq,
  input  logic            ext_irq,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            stall,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc
);

  trap_state_t state, state_nxt;

  logic            irq_pend;
  logic [XLEN-2:0] irq_cause;
  logic            take_trap;
  logic            take_mret;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-2:0] cause_q;
  logic [XLEN-1:0] mstatus_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;

  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] status_trap;
  logic [XLEN-1:0] status_mret;

  // only MTIE/MEIE of mie matter here
  logic unused_mie;
  assign unused_mie = ^{mie_i[XLEN-1:MIE_MEIE+1],
                        mie_i[MIE_MEIE-1:MIE_MTIE+1],
                        mie_i[MIE_MTIE-1:0]};

  csr_irq_select #(
    .XLEN        (XLEN),
    .TIMER_CAUSE (TIMER_CAUSE),
    .EXT_CAUSE   (EXT_CAUSE)
  ) u_irq_select (
    .mstatus_mie (mstatus_i[MSTATUS_MIE]),
    .mie_mtie    (mie_i[MIE_MTIE]),
    .mie_meie    (mie_i[MIE_MEIE]),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .irq_pend    (irq_pend),
    .cause       (irq_cause)
  );

  // interrupt wins a tie with mret; mepc then holds the mret PC
  assign take_trap = (state == IDLE) & instr_valid & irq_pend;
  assign take_mret = (state == IDLE) & instr_valid & is_mret & ~irq_pend;
  assign stall     = (state != IDLE) | take_trap | take_mret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
    end else if (take_trap) begin
      pc_q      <= pc_i;
      cause_q   <= irq_cause;
      mstatus_q <= mstatus_i;
      mtvec_q   <= mtvec_i;
    end else if (take_mret) begin
      mstatus_q <= mstatus_i;
      mepc_q    <= mepc_i;
    end
  end

  assign trap_base = {mtvec_q[XLEN-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
  assign trap_target = (mtvec_q[1:0] == 2'b01)
                       ? trap_base + ({1'b0, cause_q} << 2)
                       : trap_base;
`else
  logic unused_mode;
  assign unused_mode = ^mtvec_q[1:0];
  assign trap_target = trap_base;
`endif

  always_comb begin
    status_trap                                = mstatus_q;
    status_trap[MSTATUS_MPIE]                  = mstatus_q[MSTATUS_MIE];
    status_trap[MSTATUS_MIE]                   = 1'b0;
    status_trap[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    status_mret                                = mstatus_q;
    status_mret[MSTATUS_MIE]                   = mstatus_q[MSTATUS_MPIE];
    status_mret[MSTATUS_MPIE]                  = 1'b1;
    status_mret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    state_nxt   = state;
    csr_we      = 1'b0;
    csr_waddr   = '0;
    csr_wdata   = '0;
    redirect    = 1'b0;
    redirect_pc = '0;
    case (state)
      IDLE: begin
        if (take_trap) begin
          state_nxt = SAVE_EPC;
        end else if (take_mret) begin
          state_nxt = MRET_STATUS;
        end
      end
      SAVE_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = pc_q;
        state_nxt = SAVE_CAUSE;
      end
      SAVE_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = {1'b1, cause_q};
        state_nxt = SAVE_STATUS;
      end
      SAVE_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = status_trap;
        state_nxt = TRAP_JMP;
      end
      TRAP_JMP: begin
        redirect    = 1'b1;
        redirect_pc = trap_target;
        state_nxt   = IDLE;
      end
      MRET_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = status_mret;
        state_nxt = MRET_JMP;
      end
      MRET_JMP: begin
        redirect    = 1'b1;
        redirect_pc = mepc_q;
        state_nxt   = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] pc_i;
  logic        is_mret;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        rd;
    logic [31:0] rpc;
    logic        stall;
  } exp_t;

  csr_trap_ctrl #(.XLEN(32), .TIMER_CAUSE(7), .EXT_CAUSE(11)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .pc_i        (pc_i),
    .is_mret     (is_mret),
    .timer_irq   (timer_irq),
    .ext_irq     (ext_irq),
    .mstatus_i   (mstatus_i),
    .mie_i       (mie_i),
    .mtvec_i     (mtvec_i),
    .mepc_i      (mepc_i),
    .csr_we      (csr_we),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input exp_t e);
    exp_t o;
    o = {csr_we, csr_waddr, csr_wdata, redirect, redirect_pc, stall};
    n_cmp++;
    assert (o === e)
    else begin
      n_err++;
      $error("FAIL %s observed we=%0b addr=%h data=%h rd=%0b rpc=%h stall=%0b expected we=%0b addr=%h data=%h rd=%0b rpc=%h stall=%0b",
             tag, o.we, o.addr, o.data, o.rd, o.rpc, o.stall,
             e.we, e.addr, e.data, e.rd, e.rpc, e.stall);
    end
  endtask

  task automatic clear_inputs();
    instr_valid = 1'b0;
    is_mret     = 1'b0;
    timer_irq   = 1'b0;
    ext_irq     = 1'b0;
  endtask

  // Drives one commit-point event and checks every cycle of the expected
  // reaction, built from the architectural trap/mret rules. With hold=1
  // the inputs stay asserted, so the final IDLE cycle must retake.
  task automatic run_txn(input string tag, input bit iv, input bit mret,
                         input bit tirq, input bit eirq,
                         input logic [31:0] ms, input logic [31:0] mie,
                         input logic [31:0] mtvec, input logic [31:0] mepc,
                         input logic [31:0] pc, input bit hold);
    exp_t q[$];
    bit          ext_hit, tmr_hit, pend;
    int          cause;
    logic [31:0] st, tgt;
    @(negedge clk);
    instr_valid = iv;  is_mret = mret; timer_irq = tirq; ext_irq = eirq;
    mstatus_i = ms;    mie_i = mie;    mtvec_i = mtvec;  mepc_i = mepc;
    pc_i = pc;
    ext_hit = eirq && mie[11];
    tmr_hit = tirq && mie[7];
    pend    = ms[3] && (ext_hit || tmr_hit);
    cause   = ext_hit ? 11 : 7;
    if (iv && pend) begin
      st = ms; st[7] = ms[3]; st[3] = 1'b0; st[12:11] = 2'b11;
      tgt = mtvec & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
      if (mtvec[1:0] == 2'b01) tgt = tgt + 32'(4 * cause);
`endif
      q.push_back('{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b1});
      q.push_back('{1'b1, 12'h341, pc, 1'b0, 32'h0, 1'b1});
      q.push_back('{1'b1, 12'h342, 32'h8000_0000 | 32'(cause), 1'b0, 32'h0, 1'b1});
      q.push_back('{1'b1, 12'h300, st, 1'b0, 32'h0, 1'b1});
      q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, tgt, 1'b1});
    end else if (iv && mret) begin
      st = ms; st[3] = ms[7]; st[7] = 1'b1; st[12:11] = 2'b11;
      q.push_back('{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b1});
      q.push_back('{1'b1, 12'h300, st, 1'b0, 32'h0, 1'b1});
      q.push_back('{1'b0, 12'h000, 32'h0, 1'b1, mepc, 1'b1});
    end else begin
      q.push_back('{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, 1'b0});
    end
    q.push_back('{1'b0, 12'h000, 32'h0, 1'b0, 32'h0, hold && iv && (pend || mret)});
    foreach (q[i]) begin
      if (i > 0) begin
        @(negedge clk);
        if (i == 1 && !hold) clear_inputs();
      end
      #1;
      check($sformatf("%s[%0d]", tag, i), q[i]);
    end
    if (hold) begin
      @(negedge clk);
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  exp_t zero;

  initial begin
    zero = '0;
    rst = 1'b1;
    clear_inputs();
    pc_i = '0; mstatus_i = '0; mie_i = '0; mtvec_i = '0; mepc_i = '0;
    #12;
    check("reset_outputs", zero);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_after_reset", zero);

    run_txn("timer_trap", 1, 0, 1, 0, 32'h8, 32'h80, 32'h200, 32'h0, 32'h100, 0);
    run_txn("ext_over_timer", 1, 0, 1, 1, 32'h8, 32'h880, 32'h400, 32'h0, 32'h2000, 0);
    run_txn("mret", 1, 1, 0, 0, 32'h1880, 32'h0, 32'h0, 32'h104, 32'h50, 0);
    run_txn("irq_beats_mret", 1, 1, 1, 0, 32'h8, 32'h80, 32'h300, 32'h104, 32'h60, 0);
    run_txn("mie_off", 1, 0, 1, 1, 32'h0, 32'h880, 32'h200, 32'h0, 32'h100, 0);
    run_txn("no_valid", 0, 0, 1, 1, 32'h8, 32'h880, 32'h200, 32'h0, 32'h100, 0);
    run_txn("no_valid_mret", 0, 1, 0, 0, 32'h1880, 32'h0, 32'h0, 32'h104, 32'h100, 0);
    run_txn("src_disabled", 1, 0, 1, 1, 32'h8, 32'h0, 32'h200, 32'h0, 32'h100, 0);
    run_txn("vectored_mode", 1, 0, 0, 1, 32'h8, 32'h800, 32'h201, 32'h0, 32'h100, 0);
    run_txn("level_retaken", 1, 0, 1, 0, 32'h8, 32'h80, 32'h200, 32'h0, 32'h140, 1);

    // reset in the middle of a trap sequence
    @(negedge clk);
    instr_valid = 1'b1; timer_irq = 1'b1;
    mstatus_i = 32'h8; mie_i = 32'h80; mtvec_i = 32'h200; pc_i = 32'h180;
    @(negedge clk);
    clear_inputs();
    @(posedge clk);
    #2;
    check("pre_reset_save_cause",
          '{1'b1, 12'h342, 32'h8000_0007, 1'b0, 32'h0, 1'b1});
    rst = 1'b1;
    #1;
    check("reset_mid_sequence", zero);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_after_abort", zero);
    @(negedge clk);
    #1;
    check("still_idle_after_abort", zero);

    for (int k = 0; k < 150; k++) begin
      logic [31:0] ms, mie;
      ms  = $urandom;
      if ($urandom_range(0, 3) != 0) ms[3] = 1'b1;
      mie = $urandom;
      run_txn($sformatf("rand%0d", k), $urandom_range(0, 6) != 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, ms, mie, $urandom, $urandom,
              $urandom, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
